// File: rtl/banner_ctrl_if.sv
// Event and banner-overlay signals between the game-flow controller and its neighbours.
// The slave side is the controller; the master side is the event source / renderer pair.
interface banner_ctrl_if #(
  parameter int NUM_IMAGES = 4,
  localparam int BW = $clog2(NUM_IMAGES)
);
  logic          i_start;
  logic          i_pause;
  logic          i_game_over;
  logic          i_level_done;
  logic          i_regen_done;
  logic          i_frame_start;
  logic [BW-1:0] o_banner_num;
  logic          o_banner_show;
  logic          o_game_run;
  logic          o_regen_req;

  modport master (
    output i_start, i_pause, i_game_over, i_level_done, i_regen_done, i_frame_start,
    input  o_banner_num, o_banner_show, o_game_run, o_regen_req
  );

  modport slave (
    input  i_start, i_pause, i_game_over, i_level_done, i_regen_done, i_frame_start,
    output o_banner_num, o_banner_show, o_game_run, o_regen_req
  );
endinterface

// File: rtl/banner_ctrl.sv
// Game-flow FSM: sequences banner overlay, gates game logic, and handshakes level regeneration.
// Banner changes are shadowed and applied only at frame start to avoid tearing.
module banner_ctrl #(
  parameter int NUM_IMAGES       = 4,
  parameter int REGEN_MIN_FRAMES = 60,
  parameter int GO_HOLD_FRAMES   = 120,
  localparam int BW      = $clog2(NUM_IMAGES),
  localparam int CNT_MAX = (REGEN_MIN_FRAMES > GO_HOLD_FRAMES) ? REGEN_MIN_FRAMES : GO_HOLD_FRAMES,
  localparam int CW      = $clog2(CNT_MAX + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  banner_ctrl_if.slave bus
);

  // Encodings double as banner codes; PLAY has no banner.
  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_PAUSE     = 3'd1,
    S_GAME_OVER = 3'd2,
    S_REGEN     = 3'd3,
    S_PLAY      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic          req_q;
  logic          run_q;
  logic          show_q;
  logic [BW-1:0] num_q;
  logic          entering;
  logic          counting;

  always_comb begin
    // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_INIT:      if (bus.i_start) state_d = S_REGEN;
      S_PLAY: begin
        if (bus.i_game_over)       state_d = S_GAME_OVER;
        else if (bus.i_level_done) state_d = S_REGEN;
        else if (bus.i_pause)      state_d = S_PAUSE;
      end
      S_PAUSE:     if (bus.i_pause || bus.i_start) state_d = S_PLAY;
      S_REGEN:     if (done_q && (cnt_q >= CW'(REGEN_MIN_FRAMES))) state_d = S_PLAY;
      S_GAME_OVER: if (bus.i_start && (cnt_q >= CW'(GO_HOLD_FRAMES))) state_d = S_REGEN;
      default:     state_d = S_INIT;
    endcase
  end

  assign entering = (state_d != state_q);
  assign counting = (state_q == S_REGEN) || (state_q == S_GAME_OVER);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      run_q   <= 1'b0;
      show_q  <= 1'b1;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= (state_d == S_PLAY);

      // Entry clear wins over a coincident frame count for the state being left.
      if (entering && ((state_d == S_REGEN) || (state_d == S_GAME_OVER))) begin
        cnt_q <= '0;
      end else if (bus.i_frame_start && counting && (cnt_q != CW'(CNT_MAX))) begin
        cnt_q <= cnt_q + CW'(1);
      end

      // req is only ever high inside REGEN, so a stray done outside it is ignored.
      if (entering && (state_d == S_REGEN)) begin
        req_q  <= 1'b1;
        done_q <= 1'b0;
      end else if (req_q && bus.i_regen_done) begin
        req_q  <= 1'b0;
        done_q <= 1'b1;
      end

      if (bus.i_frame_start) begin
        show_q <= (state_q != S_PLAY);
        if (state_q != S_PLAY) num_q <= BW'(state_q);
      end
    end
  end

  assign bus.o_banner_num  = num_q;
  assign bus.o_banner_show = show_q;
  assign bus.o_game_run    = run_q;
  assign bus.o_regen_req   = req_q;

endmodule

// File: tb/tb_banner_ctrl.sv
// Bench for banner_ctrl: directed scenarios with fixed expectations, then random traffic
// checked against a rule-level model of the game flow.
module tb_banner_ctrl;

  localparam bit [6:0] ST  = 7'h01;
  localparam bit [6:0] PA  = 7'h02;
  localparam bit [6:0] GO  = 7'h04;
  localparam bit [6:0] LD  = 7'h08;
  localparam bit [6:0] RD  = 7'h10;
  localparam bit [6:0] FS  = 7'h20;
  localparam bit [6:0] RST = 7'h40;

  localparam int MIN_FR  = 4;
  localparam int HOLD_FR = 3;

  localparam int M_INIT = 0, M_PAUSE = 1, M_GO = 2, M_REGEN = 3, M_PLAY = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  banner_ctrl_if #(.NUM_IMAGES(4)) bif ();

  banner_ctrl #(
    .NUM_IMAGES(4),
    .REGEN_MIN_FRAMES(MIN_FR),
    .GO_HOLD_FRAMES(HOLD_FR)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: game flow from the rules, with an unbounded frame counter.
  int       m_state  = M_INIT;
  int       m_frames = 0;
  bit       m_done   = 1'b0;
  bit       m_req    = 1'b0;
  bit       m_run    = 1'b0;
  bit       m_show   = 1'b1;
  bit [1:0] m_num    = 2'd0;

  always @(posedge clk) begin : model
    int ns;
    if (!rst_n) begin
      m_state <= M_INIT; m_frames <= 0; m_done <= 1'b0; m_req <= 1'b0;
      m_run <= 1'b0; m_show <= 1'b1; m_num <= 2'd0;
    end else begin
      ns = m_state;
      case (m_state)
        M_INIT:  if (bif.i_start) ns = M_REGEN;
        M_PLAY:  ns = bif.i_game_over ? M_GO : bif.i_level_done ? M_REGEN :
                      bif.i_pause ? M_PAUSE : M_PLAY;
        M_PAUSE: if (bif.i_pause || bif.i_start) ns = M_PLAY;
        M_REGEN: if (m_done && m_frames >= MIN_FR) ns = M_PLAY;
        M_GO:    if (bif.i_start && m_frames >= HOLD_FR) ns = M_REGEN;
        default: ns = M_INIT;
      endcase
      if (ns != m_state && (ns == M_REGEN || ns == M_GO)) m_frames <= 0;
      else if (bif.i_frame_start && (m_state == M_REGEN || m_state == M_GO)) m_frames <= m_frames + 1;
      if (ns != m_state && ns == M_REGEN) begin
        m_req <= 1'b1; m_done <= 1'b0;
      end else if (m_req && bif.i_regen_done) begin
        m_req <= 1'b0; m_done <= 1'b1;
      end
      if (bif.i_frame_start) begin
        m_show <= (m_state != M_PLAY);
        if (m_state != M_PLAY) m_num <= 2'(m_state);
      end
      m_run   <= (ns == M_PLAY);
      m_state <= ns;
    end
  end

  function automatic logic [4:0] obs();
    return {bif.o_banner_num, bif.o_banner_show, bif.o_game_run, bif.o_regen_req};
  endfunction

  // Drive one cycle of inputs at the falling edge; return just after the rising edge.
  task automatic tick(input bit [6:0] c);
    @(negedge clk);
    bif.i_start       = c[0];
    bif.i_pause       = c[1];
    bif.i_game_over   = c[2];
    bif.i_level_done  = c[3];
    bif.i_regen_done  = c[4];
    bif.i_frame_start = c[5];
    rst_n             = ~c[6];
    @(posedge clk);
    #1;
  endtask

  // Expected vectors are {num[1:0], show, run, req}.
  task automatic test_reset();
    repeat (3) tick(RST);
    n_vec++; if (obs() !== 5'b00_1_0_0) begin n_err++; $display("FAIL reset: got %b want %b", obs(), 5'b00100); end
    tick(0); tick(0); tick(FS);
    n_vec++; if (obs() !== 5'b00_1_0_0) begin n_err++; $display("FAIL reset_idle: got %b want %b", obs(), 5'b00100); end
  endtask

  task automatic test_start_regen();
    tick(ST);
    n_vec++; if (obs() !== 5'b00_1_0_1) begin n_err++; $display("FAIL start_req: got %b want %b", obs(), 5'b00101); end
    tick(FS); tick(FS);
    n_vec++; if (obs() !== 5'b11_1_0_1) begin n_err++; $display("FAIL regen_banner: got %b want %b", obs(), 5'b11101); end
    tick(RD);
    n_vec++; if (obs() !== 5'b11_1_0_0) begin n_err++; $display("FAIL regen_done: got %b want %b", obs(), 5'b11100); end
    tick(FS); tick(FS);
    n_vec++; if (obs() !== 5'b11_1_0_0) begin n_err++; $display("FAIL regen_min_hold: got %b want %b", obs(), 5'b11100); end
    tick(0);
    n_vec++; if (obs() !== 5'b11_1_1_0) begin n_err++; $display("FAIL regen_to_play: got %b want %b", obs(), 5'b11110); end
    tick(FS);
    n_vec++; if (obs() !== 5'b11_0_1_0) begin n_err++; $display("FAIL play_hide: got %b want %b", obs(), 5'b11010); end
  endtask

  task automatic test_late_done();
    tick(LD);
    n_vec++; if (obs() !== 5'b11_0_0_1) begin n_err++; $display("FAIL level_done: got %b want %b", obs(), 5'b11001); end
    repeat (10) tick(FS);
    n_vec++; if (obs() !== 5'b11_1_0_1) begin n_err++; $display("FAIL late_wait: got %b want %b", obs(), 5'b11101); end
    tick(RD);
    n_vec++; if (obs() !== 5'b11_1_0_0) begin n_err++; $display("FAIL late_done: got %b want %b", obs(), 5'b11100); end
    tick(0);
    n_vec++; if (obs() !== 5'b11_1_1_0) begin n_err++; $display("FAIL late_play: got %b want %b", obs(), 5'b11110); end
    tick(FS);
  endtask

  task automatic test_pause();
    tick(PA);
    n_vec++; if (obs() !== 5'b11_0_0_0) begin n_err++; $display("FAIL pause_run: got %b want %b", obs(), 5'b11000); end
    tick(FS);
    n_vec++; if (obs() !== 5'b01_1_0_0) begin n_err++; $display("FAIL pause_banner: got %b want %b", obs(), 5'b01100); end
    tick(PA | ST); tick(0);
    n_vec++; if (obs() !== 5'b01_1_1_0) begin n_err++; $display("FAIL pause_resume: got %b want %b", obs(), 5'b01110); end
    tick(FS);
    n_vec++; if (obs() !== 5'b01_0_1_0) begin n_err++; $display("FAIL resume_hide: got %b want %b", obs(), 5'b01010); end
  endtask

  task automatic test_priority();
    tick(GO | LD);
    n_vec++; if (obs() !== 5'b01_0_0_0) begin n_err++; $display("FAIL prio_state: got %b want %b", obs(), 5'b01000); end
    tick(FS);
    n_vec++; if (obs() !== 5'b10_1_0_0) begin n_err++; $display("FAIL prio_banner: got %b want %b", obs(), 5'b10100); end
  endtask

  task automatic test_hold();
    tick(FS); tick(ST); tick(0);
    n_vec++; if (obs() !== 5'b10_1_0_0) begin n_err++; $display("FAIL hold_early: got %b want %b", obs(), 5'b10100); end
    tick(FS); tick(ST);
    n_vec++; if (obs() !== 5'b10_1_0_1) begin n_err++; $display("FAIL hold_restart: got %b want %b", obs(), 5'b10101); end
    tick(RST);
    n_vec++; if (obs() !== 5'b00_1_0_0) begin n_err++; $display("FAIL hold_reset: got %b want %b", obs(), 5'b00100); end
    tick(ST);
    n_vec++; if (obs() !== 5'b00_1_0_1) begin n_err++; $display("FAIL reset_init: got %b want %b", obs(), 5'b00101); end
  endtask

  task automatic test_random();
    bit [6:0] c;
    for (int i = 0; i < 3000; i++) begin
      c = '0;
      c[0] = ($urandom_range(7) == 0);
      c[1] = ($urandom_range(9) == 0);
      c[2] = ($urandom_range(29) == 0);
      c[3] = ($urandom_range(19) == 0);
      c[4] = ($urandom_range(5) == 0);
      c[5] = ($urandom_range(4) == 0);
      c[6] = ($urandom_range(299) == 0);
      tick(c);
      n_vec++;
      if (obs() !== {m_num, m_show, m_run, m_req}) begin
        n_err++;
        $display("FAIL random[%0d]: got %b want %b", i, obs(), {m_num, m_show, m_run, m_req});
      end
    end
  endtask

  initial begin
    bif.i_start = 1'b0; bif.i_pause = 1'b0; bif.i_game_over = 1'b0;
    bif.i_level_done = 1'b0; bif.i_regen_done = 1'b0; bif.i_frame_start = 1'b0;
    test_reset();
    test_start_regen();
    test_late_done();
    test_pause();
    test_priority();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
